// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and constants for mem_arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [3:0]  FETCH_BE  = 4'hF;

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - mem_ack wait counter; expired is high in the last allowed busy cycle
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = active && !ack && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || !active) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one SRAM port between fetch and data with starvation guard
// Optional ARB_TIMEOUT_EN: mem_ack watchdog that completes a hung access with bus_err.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    localparam int RW = $clog2(MAX_DATA_RUN + 1);

    arb_state_t    state, state_next;
    logic [RW-1:0] run;
    logic          discard;
    logic          is_fetch;
    logic          grant_data, grant_fetch;
    logic          timeout_hit;

`ifdef ARB_TIMEOUT_EN
    logic timed_out;

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (grant_data || grant_fetch),
        .active ((state == FETCH) || (state == DATA)),
        .ack    (mem_ack),
        .expired(timeout_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timed_out <= 1'b0;
        end else if (grant_data || grant_fetch) begin
            timed_out <= 1'b0;
        end else if (timeout_hit) begin
            timed_out <= 1'b1;
        end
    end

    assign bus_err = (state == RESP) && timed_out;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    // A flush in the response cycle itself must still hide the stale instruction.
    assign if_ready = (state == RESP) && is_fetch && !discard && !if_flush;
    assign d_ready  = (state == RESP) && !is_fetch;

    always_comb begin
        state_next  = state;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(if_req && run == RW'(MAX_DATA_RUN))) begin
                    grant_data = 1'b1;
                    state_next = DATA;
                end else if (if_req && !if_flush) begin
                    grant_fetch = 1'b1;
                    state_next  = FETCH;
                end
            end
            FETCH, DATA: begin
                if (mem_ack || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            run       <= '0;
            discard   <= 1'b0;
            is_fetch  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (!if_req || grant_fetch) begin
                        run <= '0;
                    end else if (grant_data && run != RW'(MAX_DATA_RUN)) begin
                        run <= run + 1'b1;
                    end
                    if (grant_data) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                        is_fetch  <= 1'b0;
                    end else if (grant_fetch) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= FETCH_BE;
                        is_fetch  <= 1'b1;
                    end
                end
                FETCH, DATA: begin
                    if (state == FETCH && if_flush) begin
                        discard <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (state == FETCH) begin
                            if_rdata <= mem_rdata;
                        end else begin
                            d_rdata <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        if (state == FETCH) begin
                            if_rdata <= NOP_INSTR;
                        end else begin
                            d_rdata <= '0;
                        end
                    end
                end
                RESP: begin
                    discard <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_req, mem_we, bus_err;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
    mem_arbiter #(.MAX_DATA_RUN(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );
`else
    mem_arbiter #(.MAX_DATA_RUN(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    logic [31:0] phys    [0:15];
    logic [31:0] ref_mem [0:15];

    initial begin
        int          dcount, hi, lat, tb_run, d_idx, rsel;
        logic        got, prev_mem_req, be_seen;
        logic [31:0] rd_seen;

        reset = 1'b0; if_req = 0; if_flush = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; d_be = 0; mem_ack = 0; mem_rdata = 0;
        step(); step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        reset = 1'b1;
        step();

        // Fetch only, ack one cycle after mem_req rises
        if_req = 1; if_addr = 32'h100;
        step();
        chk("f_mem_req", mem_req, 1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_be", mem_be, 4'hF);
        chk("f_mem_we", mem_we, 0);
        step();
        chk("f_if_ready_early", if_ready, 0);
        mem_ack = 1; mem_rdata = 32'h00A0_0093;
        step();
        chk("f_if_ready", if_ready, 1);
        chk("f_if_rdata", if_rdata, 32'h00A0_0093);
        chk("f_mem_req_drop", mem_req, 0);
        mem_ack = 0; if_req = 0;
        step();
        chk("f_if_ready_pulse", if_ready, 0);
        chk("f_if_rdata_hold", if_rdata, 32'h00A0_0093);

        // Contention: store wins, fetch follows
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
        if_req = 1; if_addr = 32'h120;
        step();
        chk("c_mem_we", mem_we, 1);
        chk("c_mem_be", mem_be, 4'h3);
        chk("c_mem_addr", mem_addr, 32'h2000);
        chk("c_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1;
        step();
        chk("c_d_ready", d_ready, 1);
        chk("c_if_ready_none", if_ready, 0);
        mem_ack = 0; d_req = 0;
        step();
        chk("c_idle_mem_req", mem_req, 0);
        step();
        chk("c_fetch_req", mem_req, 1);
        chk("c_fetch_addr", mem_addr, 32'h120);
        mem_ack = 1; mem_rdata = 32'h1111_2222;
        step();
        chk("c_if_ready", if_ready, 1);
        chk("c_if_rdata", if_rdata, 32'h1111_2222);
        mem_ack = 0; if_req = 0;
        step();

        // Starvation guard: four data accesses then the pending fetch
        d_req = 1; d_we = 0; d_addr = 32'h2004; d_be = 4'hF;
        if_req = 1; if_addr = 32'h140;
        dcount = 0; got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (d_ready) dcount++;
            if (if_ready) got = 1;
            mem_ack   = mem_req && !mem_ack;
            mem_rdata = init_word(mem_addr);
        end
        chk("s_fetch_served", got, 1);
        chk("s_data_count", dcount, 4);
        d_req = 0; if_req = 0; mem_ack = 0;
        step(); step();

        // Flush in flight: no if_ready, next grant uses the new PC
        if_req = 1; if_addr = 32'h104;
        step();
        chk("fl_addr_old", mem_addr, 32'h104);
        if_flush = 1; if_addr = 32'h200;
        step();
        if_flush = 0; mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
        step();
        chk("fl_no_ready_resp", if_ready, 0);
        mem_ack = 0;
        step();
        chk("fl_no_ready_idle", if_ready, 0);
        step();
        chk("fl_new_req", mem_req, 1);
        chk("fl_new_addr", mem_addr, 32'h200);
        mem_ack = 1; mem_rdata = 32'h0000_0297;
        step();
        chk("fl_ready", if_ready, 1);
        chk("fl_rdata", if_rdata, 32'h0000_0297);
        mem_ack = 0; if_req = 0;
        step();

        // Async reset in the middle of a data access
        d_req = 1; d_we = 0; d_addr = 32'h2008; d_be = 4'hF;
        step();
        chk("r_mem_req_before", mem_req, 1);
        reset = 0;
        #1;
        chk("r_mem_req_async", mem_req, 0);
        chk("r_d_ready", d_ready, 0);
        chk("r_mem_addr", mem_addr, 0);
        d_req = 0;
        step();
        reset = 1;
        step(); step();
        chk("r_no_d_ready", d_ready, 0);
        chk("r_idle_mem_req", mem_req, 0);

`ifdef ARB_TIMEOUT_EN
        // Watchdog completes a never-acked fetch with NOP and bus_err
        if_req = 1; if_addr = 32'h180;
        hi = 0; got = 0; be_seen = 0; rd_seen = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (mem_req) hi++;
            if (if_ready) begin
                got = 1; be_seen = bus_err; rd_seen = if_rdata;
            end
        end
        chk("t_ready", got, 1);
        chk("t_req_cycles", hi, 8);
        chk("t_bus_err", be_seen, 1);
        chk("t_nop", rd_seen, 32'h0000_0013);
        if_req = 0;
        step();
        chk("t_bus_err_pulse", bus_err, 0);
        mem_ack = 1;
        step();
        mem_ack = 0;
        chk("t_late_ack_if", if_ready, 0);
        chk("t_late_ack_d", d_ready, 0);
        step();
`endif

        // Randomized traffic against a memory/requester reference
        for (int i = 0; i < 16; i++) begin
            phys[i]    = init_word(32'h2000 + i * 4);
            ref_mem[i] = phys[i];
        end
        if_req = 0; d_req = 0; if_flush = 0; mem_ack = 0;
        prev_mem_req = 0; tb_run = 0; lat = 0; d_idx = 0;
        for (int cyc = 0; cyc < 3200; cyc++) begin
            step();
            chk("rnd_bus_err", bus_err, 0);
            if (d_ready) begin
                if (!d_we) chk("rnd_load", d_rdata, ref_mem[d_idx]);
                else ref_mem[d_idx] = merge(ref_mem[d_idx], d_wdata, d_be);
                d_req = 0;
            end
            if (if_ready) begin
                chk("rnd_fetch", if_rdata, init_word(if_addr));
                if_req = 0;
            end
            if (mem_req && !prev_mem_req) begin
                if (mem_addr >= 32'h2000) begin
                    chk("rnd_d_addr", mem_addr, d_addr);
                    chk("rnd_d_we", mem_we, d_we);
                    chk("rnd_d_wdata", mem_wdata, d_wdata);
                    chk("rnd_d_be", mem_be, d_be);
                    if (if_req) begin
                        tb_run++;
                        chk("rnd_run_bound", tb_run <= 4, 1);
                    end
                end else begin
                    chk("rnd_f_addr", mem_addr, if_addr);
                    chk("rnd_f_be", mem_be, 4'hF);
                    if (d_req) chk("rnd_f_prio", tb_run, 4);
                    tb_run = 0;
                end
                lat = $urandom_range(0, 3);
            end
            if (!if_req) tb_run = 0;
            prev_mem_req = mem_req;
            if (mem_ack) begin
                mem_ack = 0;
            end else if (mem_req) begin
                if (lat == 0) begin
                    mem_ack = 1;
                    if (mem_addr >= 32'h2000) begin
                        if (mem_we) begin
                            phys[mem_addr[5:2]] = merge(phys[mem_addr[5:2]], mem_wdata, mem_be);
                            mem_rdata = $urandom;
                        end else begin
                            mem_rdata = phys[mem_addr[5:2]];
                        end
                    end else begin
                        mem_rdata = init_word(mem_addr);
                    end
                end else begin
                    lat--;
                end
            end
            if_flush = 0;
            if (cyc < 3000) begin
                if (!d_req && $urandom_range(0, 2) == 0) begin
                    d_req   = 1;
                    d_we    = 1'($urandom_range(0, 1));
                    d_idx   = $urandom_range(0, 15);
                    d_addr  = 32'h2000 + 32'(d_idx) * 4;
                    d_wdata = $urandom;
                    d_be    = 4'($urandom_range(1, 15));
                end
                if (!if_req && $urandom_range(0, 2) == 0) begin
                    if_req  = 1;
                    if_addr = 32'($urandom_range(0, 63)) * 4;
                end else if (if_req && $urandom_range(0, 9) == 0) begin
                    rsel     = $urandom_range(1, 63);
                    if_flush = 1;
                    if_addr  = 32'(((if_addr >> 2) + 32'(rsel)) % 64) * 4;
                end
            end
        end
        chk("rnd_drained", {30'b0, d_req, if_req}, 0);
        chk("rnd_idle", mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
